// File: rtl/sync_capture_ctrl.sv
// sync_capture_ctrl: trigger evaluation and pre/armed/post/holdoff capture sequencing.
// Define SYNC_TRIG_ADDR_EN to add the WR_ADDR / TRIG_ADDR write-address outputs.
module sync_capture_ctrl #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLK_EN,
  input  logic [DW-1:0]    SYNC_DATA_IN,
  input  logic [DW-1:0]    TRG_LV_UP,
  input  logic [DW-1:0]    TRG_LV_DOWN,
  input  logic [DW-1:0]    LA_MASK_CND,
  input  logic [DW-1:0]    LA_MASK_DIFF,
  input  logic             SYNC_SOURCE,
  input  logic [1:0]       ADC_MODE,
  input  logic [1:0]       LA_MODE,
  input  logic [1:0]       RUN_MODE,
  input  logic [CNT_W-1:0] PRE_CNT,
  input  logic [CNT_W-1:0] POST_CNT,
  input  logic [CNT_W-1:0] HOLDOFF,
  input  logic [CNT_W-1:0] AUTO_TMO,
  input  logic             START,
  input  logic             ABORT,
  output logic             SRAM_WR,
  output logic             WIN_CNT_EN,
  output logic             TRIG_EVENT,
  output logic             TRIG_FORCED,
  output logic             BUSY,
  output logic             DONE
`ifdef SYNC_TRIG_ADDR_EN
  ,
  output logic [CNT_W-1:0] WR_ADDR,
  output logic [CNT_W-1:0] TRIG_ADDR
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DW-1:0]    DW_ZERO  = {DW{1'b0}};

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] tmo_q;
  logic [DW-1:0]    prev_q;
  logic             arm_rise_q;
  logic             arm_fall_q;
  logic             sram_wr_q;
  logic             trig_event_q;
  logic             forced_q;
  logic             done_q;

  logic             arm_rise_d;
  logic             arm_fall_d;
  logic             win_ok_s;
  logic             in_cur_s;
  logic             in_prev_s;
  logic             rise_fire_s;
  logic             fall_fire_s;
  logic             adc_trig_s;
  logic             pat_s;
  logic             edge_s;
  logic             la_trig_s;
  logic             trig_s;
  logic             tmo_hit_s;
  logic             fire_s;
  state_t           rearm_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // True on the sample that completes a run of lim samples; lim=0 behaves like 1.
  function automatic logic last_of(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] lim);
    return ({1'b0, cnt} + {1'b0, CNT_ONE}) >= {1'b0, lim};
  endfunction

  assign rearm_s = (PRE_CNT != CNT_ZERO) ? S_PRE : S_ARMED;

  // Trigger evaluation on the current sample and next values of the hysteresis arm flags.
  always_comb begin
    win_ok_s    = (TRG_LV_DOWN <= TRG_LV_UP);
    in_cur_s    = win_ok_s && (SYNC_DATA_IN >= TRG_LV_DOWN) && (SYNC_DATA_IN <= TRG_LV_UP);
    in_prev_s   = win_ok_s && (prev_q >= TRG_LV_DOWN) && (prev_q <= TRG_LV_UP);
    rise_fire_s = arm_rise_q && (SYNC_DATA_IN >= TRG_LV_UP);
    fall_fire_s = arm_fall_q && (SYNC_DATA_IN <= TRG_LV_DOWN);
    pat_s       = ((SYNC_DATA_IN ^ TRG_LV_UP) & LA_MASK_CND) == DW_ZERO;
    edge_s      = ((SYNC_DATA_IN ^ prev_q) & LA_MASK_DIFF) != DW_ZERO;

    case (ADC_MODE)
      2'd0:    adc_trig_s = rise_fire_s;
      2'd1:    adc_trig_s = fall_fire_s;
      2'd2:    adc_trig_s = !in_prev_s && in_cur_s;
      2'd3:    adc_trig_s = in_prev_s && !in_cur_s;
      default: adc_trig_s = 1'b0;
    endcase

    case (LA_MODE)
      2'd0:    la_trig_s = pat_s;
      2'd1:    la_trig_s = edge_s;
      2'd2:    la_trig_s = pat_s && edge_s;
      default: la_trig_s = 1'b0;
    endcase

    trig_s    = SYNC_SOURCE ? la_trig_s : adc_trig_s;
    tmo_hit_s = (RUN_MODE == 2'd2) && (AUTO_TMO != CNT_ZERO) && last_of(tmo_q, AUTO_TMO);
    fire_s    = trig_s || tmo_hit_s;

    if (rise_fire_s) begin
      arm_rise_d = 1'b0;
    end else if (SYNC_DATA_IN < TRG_LV_DOWN) begin
      arm_rise_d = 1'b1;
    end else begin
      arm_rise_d = arm_rise_q;
    end

    if (fall_fire_s) begin
      arm_fall_d = 1'b0;
    end else if (SYNC_DATA_IN > TRG_LV_UP) begin
      arm_fall_d = 1'b1;
    end else begin
      arm_fall_d = arm_fall_q;
    end
  end

  // Capture sequencer with registered strobe, trigger pulse and sticky status flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      tmo_q        <= CNT_ZERO;
      prev_q       <= DW_ZERO;
      arm_rise_q   <= 1'b0;
      arm_fall_q   <= 1'b0;
      sram_wr_q    <= 1'b1;
      trig_event_q <= 1'b0;
      forced_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sram_wr_q    <= 1'b1;
      trig_event_q <= 1'b0;
      if (CLK_EN) begin
        prev_q     <= SYNC_DATA_IN;
        arm_rise_q <= arm_rise_d;
        arm_fall_q <= arm_fall_d;
      end
      if (ABORT) begin
        state_q <= S_IDLE;
        cnt_q   <= CNT_ZERO;
        tmo_q   <= CNT_ZERO;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (START) begin
              state_q  <= rearm_s;
              cnt_q    <= CNT_ZERO;
              tmo_q    <= CNT_ZERO;
              done_q   <= 1'b0;
              forced_q <= 1'b0;
            end
          end
          S_PRE: begin
            if (CLK_EN) begin
              sram_wr_q <= 1'b0;
              if (last_of(cnt_q, PRE_CNT)) begin
                state_q <= S_ARMED;
                cnt_q   <= CNT_ZERO;
              end else begin
                cnt_q <= sat_inc(cnt_q);
              end
            end
          end
          S_ARMED: begin
            if (CLK_EN) begin
              sram_wr_q <= 1'b0;
              if (fire_s) begin
                trig_event_q <= 1'b1;
                forced_q     <= !trig_s;
                cnt_q        <= CNT_ZERO;
                tmo_q        <= CNT_ZERO;
                if (POST_CNT == CNT_ZERO) begin
                  state_q <= S_HOLD;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= S_POST;
                end
              end else begin
                tmo_q <= sat_inc(tmo_q);
              end
            end
          end
          S_POST: begin
            if (CLK_EN) begin
              sram_wr_q <= 1'b0;
              if (last_of(cnt_q, POST_CNT)) begin
                state_q <= S_HOLD;
                done_q  <= 1'b1;
                cnt_q   <= CNT_ZERO;
              end else begin
                cnt_q <= sat_inc(cnt_q);
              end
            end
          end
          S_HOLD: begin
            // Single mode leaves on the next clock without waiting for a sample.
            if (RUN_MODE == 2'd1) begin
              state_q <= S_IDLE;
              cnt_q   <= CNT_ZERO;
            end else if (CLK_EN) begin
              if (last_of(cnt_q, HOLDOFF)) begin
                state_q <= rearm_s;
                cnt_q   <= CNT_ZERO;
              end else begin
                cnt_q <= sat_inc(cnt_q);
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            tmo_q   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

`ifdef SYNC_TRIG_ADDR_EN
  logic [CNT_W-1:0] wr_addr_q;
  logic [CNT_W-1:0] trig_addr_q;
  logic [CNT_W-1:0] next_addr_s;
  logic             trig_take_s;

  // WR_ADDR holds the address of the strobe in flight and advances once it retires.
  assign next_addr_s = sram_wr_q ? wr_addr_q : wr_addr_q + CNT_ONE;
  assign trig_take_s = CLK_EN && !ABORT && (state_q == S_ARMED) && fire_s;

  // Write-address counter and trigger-address latch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_addr_q   <= CNT_ZERO;
      trig_addr_q <= CNT_ZERO;
    end else begin
      if (!ABORT && START && (state_q == S_IDLE)) begin
        wr_addr_q <= CNT_ZERO;
      end else begin
        wr_addr_q <= next_addr_s;
      end
      if (trig_take_s) begin
        trig_addr_q <= next_addr_s;
      end
    end
  end

  assign WR_ADDR   = wr_addr_q;
  assign TRIG_ADDR = trig_addr_q;
`endif

  assign SRAM_WR     = sram_wr_q;
  assign WIN_CNT_EN  = ~sram_wr_q;
  assign TRIG_EVENT  = trig_event_q;
  assign TRIG_FORCED = forced_q;
  assign BUSY        = (state_q != S_IDLE);
  assign DONE        = done_q;

endmodule
